// File: rtl/life_game_stepper.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | life_game_stepper: sweeps the displayed frame and writes the next Game of |
// | Life generation to the back buffer. LIFE_GAME_TORUS_EN: wrap-around world |
// | (default build: dead border).                            Revision: 1.0    |
// +--------------------------------------------------------------------------+
module life_game_stepper #(
  parameter int WORLD_ROWS       = 48,
  parameter int GENERATION_WIDTH = 16
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        start,
  input  logic [31:0]                 cell_data_in,
  output logic                        cell_write,
  output logic [6:0]                  cell_address,
  output logic [31:0]                 cell_data_out,
  output logic                        busy,
  output logic                        step_done,
  output logic [GENERATION_WIDTH-1:0] generation
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PRE  = 3'd1;
  localparam logic [2:0] S_WLO  = 3'd2;
  localparam logic [2:0] S_WHI  = 3'd3;
  localparam logic [2:0] S_SLO  = 3'd4;
  localparam logic [2:0] S_SHI  = 3'd5;
  localparam logic [2:0] S_DONE = 3'd6;

  localparam logic [5:0] c_LAST_ROW = 6'(WORLD_ROWS - 1);
  localparam logic [6:0] c_ROWS     = 7'(WORLD_ROWS);
`ifdef LIFE_GAME_TORUS_EN
  localparam logic c_TORUS = 1'b1;
`else
  localparam logic c_TORUS = 1'b0;
`endif

  logic [2:0]                  r_state;
  logic [2:0]                  r_k;
  logic [5:0]                  r_y;
  logic [63:0]                 r_prev;
  logic [63:0]                 r_cur;
  logic [63:0]                 r_nxt;
  logic [31:0]                 r_stage;
  logic [31:0]                 r_dout;
  logic [GENERATION_WIDTH-1:0] r_gen;

  logic [6:0]  w_y2;
  logic        w_y2_wrap;
  logic [5:0]  w_row_ahead;
  logic [5:0]  w_row;
  logic        w_half;
  logic        w_kill;
  logic [31:0] w_rd;
  logic [65:0] w_pe;
  logic [65:0] w_ce;
  logic [65:0] w_ne;
  logic [63:0] w_next;

  assign w_y2        = {1'b0, r_y} + 7'd2;
  assign w_y2_wrap   = (w_y2 >= c_ROWS);
  assign w_row_ahead = w_y2_wrap ? 6'(w_y2 - c_ROWS) : w_y2[5:0];

  // Rows beyond the top/bottom edge are read for uniform timing but zeroed without wrap.
  assign w_kill = ((r_state == S_PRE) && (r_k[2:1] == 2'd0)) ||
                  (((r_state == S_SLO) || (r_state == S_SHI)) && w_y2_wrap);
  assign w_rd   = (!c_TORUS && w_kill) ? 32'h0 : cell_data_in;

  // Extended rows: index 0 is column -1, index 65 is column 64.
  assign w_pe = c_TORUS ? {r_prev[0], r_prev, r_prev[63]} : {1'b0, r_prev, 1'b0};
  assign w_ce = c_TORUS ? {r_cur[0],  r_cur,  r_cur[63]}  : {1'b0, r_cur,  1'b0};
  assign w_ne = c_TORUS ? {r_nxt[0],  r_nxt,  r_nxt[63]}  : {1'b0, r_nxt,  1'b0};

  for (genvar c = 0; c < 64; c++) begin : g_cell
    logic [3:0] w_n;
    assign w_n = {3'b000, w_pe[c]} + {3'b000, w_pe[c+1]} + {3'b000, w_pe[c+2]} +
                 {3'b000, w_ce[c]} + {3'b000, w_ce[c+2]} +
                 {3'b000, w_ne[c]} + {3'b000, w_ne[c+1]} + {3'b000, w_ne[c+2]};
    assign w_next[c] = (w_n == 4'd3) | (r_cur[c] & (w_n == 4'd2));
  end

  always_comb begin
    w_row         = 6'd0;
    w_half        = 1'b0;
    cell_write    = 1'b0;
    cell_data_out = r_dout;
    case (r_state)
      S_PRE: begin
        case (r_k[2:1])
          2'd0:    w_row = c_LAST_ROW;
          2'd1:    w_row = 6'd0;
          default: w_row = 6'd1;
        endcase
        w_half = r_k[0];
      end
      S_WLO: begin
        w_row         = r_y;
        cell_write    = 1'b1;
        cell_data_out = w_next[31:0];
      end
      S_WHI: begin
        w_row         = r_y;
        w_half        = 1'b1;
        cell_write    = 1'b1;
        cell_data_out = w_next[63:32];
      end
      S_SLO: w_row = w_row_ahead;
      S_SHI: begin
        w_row  = w_row_ahead;
        w_half = 1'b1;
      end
      default: ;
    endcase
  end

  assign cell_address = {w_row, w_half};
  assign busy         = (r_state != S_IDLE) && (r_state != S_DONE);
  assign step_done    = (r_state == S_DONE);
  assign generation   = r_gen;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_k     <= 3'd0;
      r_y     <= 6'd0;
      r_prev  <= 64'h0;
      r_cur   <= 64'h0;
      r_nxt   <= 64'h0;
      r_stage <= 32'h0;
      r_dout  <= 32'h0;
      r_gen   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_PRE;
            r_k     <= 3'd0;
          end
        end
        S_PRE: begin
          r_k <= r_k + 3'd1;
          case (r_k)
            3'd0:    r_prev[31:0]  <= w_rd;
            3'd1:    r_prev[63:32] <= w_rd;
            3'd2:    r_cur[31:0]   <= w_rd;
            3'd3:    r_cur[63:32]  <= w_rd;
            3'd4:    r_nxt[31:0]   <= w_rd;
            default: begin
              r_nxt[63:32] <= w_rd;
              r_y          <= 6'd0;
              r_state      <= S_WLO;
            end
          endcase
        end
        S_WLO: begin
          r_dout  <= w_next[31:0];
          r_state <= S_WHI;
        end
        S_WHI: begin
          r_dout  <= w_next[63:32];
          r_state <= (r_y == c_LAST_ROW) ? S_DONE : S_SLO;
        end
        S_SLO: begin
          r_stage <= w_rd;
          r_state <= S_SHI;
        end
        S_SHI: begin
          r_prev  <= r_cur;
          r_cur   <= r_nxt;
          r_nxt   <= {w_rd, r_stage};
          r_y     <= r_y + 6'd1;
          r_state <= S_WLO;
        end
        S_DONE: begin
          r_gen   <= r_gen + {{(GENERATION_WIDTH-1){1'b0}}, 1'b1};
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_life_game_stepper.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_life_game_stepper: directed bench with a two-buffer frame model.      |
// |                                                          Revision: 1.0   |
// +--------------------------------------------------------------------------+
module tb_life_game_stepper;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] cell_data_in;
  logic        cell_write;
  logic [6:0]  cell_address;
  logic [31:0] cell_data_out;
  logic        busy;
  logic        step_done;
  logic [15:0] generation;

  life_game_stepper #(.WORLD_ROWS(48), .GENERATION_WIDTH(16)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .cell_data_in(cell_data_in),
    .cell_write(cell_write), .cell_address(cell_address), .cell_data_out(cell_data_out),
    .busy(busy), .step_done(step_done), .generation(generation)
  );

  initial forever #5 clock = ~clock;

  logic [31:0] front [0:127];
  logic [31:0] back  [0:127];
  logic [31:0] expf  [0:127];
  assign cell_data_in = front[cell_address];

  int   cyc = 0;
  int   c0 = 0;
  logic arm = 1'b0;
  int   wr_cnt = 0, first_wr = 0, addr_err = 0, done_cnt = 0, done_cyc = 0;
  int   busy_cnt = 0, busy_first = 0, busy_last = 0;
  logic [6:0] exp_addr = 7'd0;
  int   n_checks = 0, n_err = 0, gen_exp = 0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(posedge clock) begin
    if (arm) begin
      for (int i = 0; i < 128; i++) back[i] <= 32'hDEADBEEF;
    end else if (cell_write) begin
      back[cell_address] <= cell_data_out;
    end
  end

  always @(negedge clock) begin
    if (arm) begin
      wr_cnt <= 0; first_wr <= 0; addr_err <= 0; done_cnt <= 0; done_cyc <= 0;
      busy_cnt <= 0; busy_first <= 0; busy_last <= 0; exp_addr <= 7'd0;
    end else begin
      if (cell_write) begin
        if (wr_cnt == 0) first_wr <= cyc - c0;
        if (cell_address !== exp_addr) addr_err <= addr_err + 1;
        exp_addr <= exp_addr + 7'd1;
        wr_cnt   <= wr_cnt + 1;
      end
      if (busy) begin
        if (busy_cnt == 0) busy_first <= cyc - c0;
        busy_last <= cyc - c0;
        busy_cnt  <= busy_cnt + 1;
      end
      if (step_done) begin
        done_cnt <= done_cnt + 1;
        done_cyc <= cyc - c0;
      end
    end
  end

  typedef struct {
    bit               ones;
    int               n_in;
    logic [7:0][11:0] ci;
    int               n_ex;
    logic [7:0][11:0] ce;
  } vec_t;
  vec_t vt [8];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  task automatic add_in(input int v, input int x, input int y);
    vt[v].ci[vt[v].n_in] = {6'(y), 6'(x)};
    vt[v].n_in++;
  endtask

  task automatic add_ex(input int v, input int x, input int y);
    vt[v].ce[vt[v].n_ex] = {6'(y), 6'(x)};
    vt[v].n_ex++;
  endtask

  task automatic exp_cell(input int x, input int y);
    expf[y*2 + x/32][x%32] = 1'b1;
  endtask

  task automatic clear_exp();
    for (int i = 0; i < 128; i++) expf[i] = 32'h0;
  endtask

  task automatic load_vec(input int v);
    int x, y;
    for (int i = 0; i < 128; i++) front[i] = (vt[v].ones && i < 96) ? 32'hFFFF_FFFF : 32'h0;
    for (int i = 0; i < vt[v].n_in; i++) begin
      x = int'(vt[v].ci[i][5:0]);
      y = int'(vt[v].ci[i][11:6]);
      front[y*2 + x/32][x%32] = 1'b1;
    end
  endtask

  task automatic build_exp(input int v);
    clear_exp();
    for (int i = 0; i < vt[v].n_ex; i++)
      exp_cell(int'(vt[v].ce[i][5:0]), int'(vt[v].ce[i][11:6]));
  endtask

  task automatic compare_frame(input string nm);
    int bad = 0, first = -1;
    for (int i = 0; i < 96; i++)
      if (back[i] !== expf[i]) begin
        bad++;
        if (first < 0) first = i;
      end
    n_checks++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL %s: %0d words wrong, word %0d got %h expected %h",
               nm, bad, first, back[first], expf[first]);
    end
  endtask

  task automatic arm_mon();
    arm = 1'b1;
    repeat (2) @(negedge clock);
    arm = 1'b0;
    @(negedge clock);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_rel(input int n);
    while ((cyc - c0) < n) @(negedge clock);
  endtask

  // One full generation, then the swap: the written frame becomes the displayed one.
  task automatic do_gen();
    int t = 0;
    arm_mon();
    c0 = cyc;
    pulse_start();
    while (done_cnt == 0 && t < 400) begin
      @(negedge clock);
      t++;
    end
    repeat (3) @(negedge clock);
    check("step_done_count", 64'(done_cnt), 64'd1);
    gen_exp++;
    for (int i = 0; i < 96; i++) front[i] = back[i];
  endtask

  initial begin
    int wr_at;
    for (int v = 0; v < 8; v++) begin
      vt[v].ones = 1'b0; vt[v].n_in = 0; vt[v].n_ex = 0; vt[v].ci = '0; vt[v].ce = '0;
    end
    add_in(0, 1, 0); add_in(0, 2, 1); add_in(0, 0, 2); add_in(0, 1, 2); add_in(0, 2, 2);
    add_ex(0, 0, 1); add_ex(0, 2, 1); add_ex(0, 1, 2); add_ex(0, 2, 2); add_ex(0, 1, 3);
    add_in(1, 31, 10); add_in(1, 32, 10); add_in(1, 33, 10);
    add_ex(1, 32, 9);  add_ex(1, 32, 10); add_ex(1, 32, 11);
    add_in(2, 62, 46); add_in(2, 63, 46); add_in(2, 62, 47); add_in(2, 63, 47);
    add_ex(2, 62, 46); add_ex(2, 63, 46); add_ex(2, 62, 47); add_ex(2, 63, 47);
    add_in(3, 62, 0); add_in(3, 63, 0); add_in(3, 0, 0);
    vt[5].ones = 1'b1;
    add_in(6, 5, 5);
    add_in(7, 0, 47); add_in(7, 0, 0); add_in(7, 0, 1);
`ifdef LIFE_GAME_TORUS_EN
    add_ex(3, 63, 47); add_ex(3, 63, 0); add_ex(3, 63, 1);
    add_ex(7, 63, 0);  add_ex(7, 0, 0);  add_ex(7, 1, 0);
`else
    add_ex(5, 0, 0); add_ex(5, 63, 0); add_ex(5, 0, 47); add_ex(5, 63, 47);
`endif

    #1;
    check("reset cell_write", 64'(cell_write), 64'd0);
    check("reset cell_address", 64'(cell_address), 64'd0);
    check("reset cell_data_out", 64'(cell_data_out), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset step_done", 64'(step_done), 64'd0);
    check("reset generation", 64'(generation), 64'd0);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    // Glider over four generations lands shifted by (+1,+1).
    load_vec(0);
    repeat (4) do_gen();
    clear_exp();
    exp_cell(2, 1); exp_cell(3, 2); exp_cell(1, 3); exp_cell(2, 3); exp_cell(3, 3);
    compare_frame("glider_4gen");
    check("generation_after_4", 64'(generation), 64'd4);

    for (int v = 0; v < 8; v++) begin
      load_vec(v);
      build_exp(v);
      do_gen();
      compare_frame($sformatf("vector%0d_frame", v));
      check($sformatf("vector%0d_writes", v), 64'(wr_cnt), 64'd96);
      check($sformatf("vector%0d_done_cycle", v), 64'(done_cyc), 64'd197);
      check($sformatf("vector%0d_generation", v), 64'(generation), 64'(gen_exp));
      if (v == 0) begin
        check("first_write_cycle", 64'(first_wr), 64'd7);
        check("write_address_order", 64'(addr_err), 64'd0);
        check("busy_first_cycle", 64'(busy_first), 64'd1);
        check("busy_last_cycle", 64'(busy_last), 64'd196);
        check("busy_cycles", 64'(busy_cnt), 64'd196);
      end
    end

    // Starts at cycles 50 and 197 (DONE) must be ignored.
    load_vec(0);
    build_exp(0);
    arm_mon();
    c0 = cyc;
    pulse_start();
    wait_rel(50);
    pulse_start();
    wait_rel(197);
    pulse_start();
    wait_rel(260);
    gen_exp++;
    check("multi_start_done_count", 64'(done_cnt), 64'd1);
    check("multi_start_writes", 64'(wr_cnt), 64'd96);
    check("multi_start_busy_last", 64'(busy_last), 64'd196);
    check("multi_start_generation", 64'(generation), 64'(gen_exp));
    compare_frame("multi_start_frame");

    // Reset mid-sweep.
    load_vec(0);
    arm_mon();
    c0 = cyc;
    pulse_start();
    wait_rel(100);
    reset_n = 1'b0;
    #1;
    check("midreset cell_write", 64'(cell_write), 64'd0);
    check("midreset cell_address", 64'(cell_address), 64'd0);
    check("midreset cell_data_out", 64'(cell_data_out), 64'd0);
    check("midreset busy", 64'(busy), 64'd0);
    check("midreset generation", 64'(generation), 64'd0);
    wr_at = wr_cnt;
    repeat (5) @(negedge clock);
    reset_n = 1'b1;
    repeat (20) @(negedge clock);
    check("midreset_no_writes", 64'(wr_cnt), 64'(wr_at));
    check("midreset_idle", 64'(busy), 64'd0);
    gen_exp = 0;
    build_exp(0);
    do_gen();
    compare_frame("after_reset_frame");
    check("after_reset_writes", 64'(wr_cnt), 64'd96);
    check("after_reset_generation", 64'(generation), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire
